lander_controller: RTL and testbench
====================================

# lander_controller

Sequencer for the lunar-lander datapath (fuel, velocity and altitude counters). It owns the game state machine:
- holds the datapath in reset until the player arms a run;
- enables one datapath step per `clk_2` tick;
- clamps each tick's burn request to the remaining fuel;
- judges the touchdown as a safe landing or a crash, and latches flight time and impact velocity for the LCD.

It sits between the switch inputs and the counter datapath, in the same top as the datapath.

## Interface
Parameters:
- `NBITS_COMB`, 8, fuel counter width
- `NBITS_BURN`, 7, burn request width
- `NBITS_VELO`, 12, signed velocity width
- `NBITS_ALT`, 12, altitude width
- `NBITS_TIME`, 8, flight-time counter width
- `SAFE_VELO`, 10, max touchdown speed (magnitude) counted as a landing

Ports:
- `clk_2`  in  1  game clock, one tick = 1 s
- `reset`  in  1  synchronous, active-high
- `start`  in  1  level switch; rising edge arms/acknowledges
- `burn_req`  in  NBITS_BURN  player burn request
- `fuel`  in  NBITS_COMB  datapath fuel counter
- `velo`  in  NBITS_VELO  datapath velocity, two's complement
- `alt`  in  NBITS_ALT  datapath altitude
- `dp_reset`  out  1  loads the datapath initial values (120 / -50 / 500)
- `step_en`  out  1  datapath advances this tick
- `burn`  out  NBITS_BURN  burn applied this tick
- `state`  out  2  0 IDLE, 1 RUN, 2 LANDED, 3 CRASHED
- `elapsed`  out  NBITS_TIME  ticks spent in RUN
- `impact_velo`  out  NBITS_VELO  velocity latched at touchdown

## Operation
- Start edge: `start_rise = start & ~start_q`. `start_q` is a register and resets to 1, so a switch already high at reset does not fire.
- Outputs decoded from state (Moore):
  - `dp_reset` = 1 only in IDLE.
  - `step_en` = 1 only in RUN.
- `burn` is combinational:
  - in RUN: `min(burn_req, fuel)` (unsigned compare, `fuel` zero-extended);
  - in every other state: 0.
- IDLE:
  - clears `elapsed` and `impact_velo` to 0;
  - `start_rise` -> RUN.
- RUN:
  - `elapsed` increments each tick and saturates at 2^NBITS_TIME-1.
  - If `alt == 0`: latch `impact_velo <= velo` and `elapsed` stops.
  - Then go to LANDED if `velo >= -SAFE_VELO` (signed compare, so any non-negative velocity counts as landed); otherwise go to CRASHED.
- LANDED / CRASHED:
  - all status is held;
  - `start_rise` -> IDLE.
  - A further `start_rise` from IDLE starts a new run.
- `alt == 0` check in RUN takes priority over `start_rise`; `start` is ignored in RUN.
- `reset` overrides everything and may be applied at any time, including mid-RUN:
  - state = IDLE, `elapsed` = 0, `impact_velo` = 0, `start_q` = 1;
  - `dp_reset` = 1 after the edge.

## Timing
- All state and status registers update on `posedge clk_2`.
- `start_rise` sampled at edge N -> RUN from edge N; `step_en` = 1 and `dp_reset` = 0 during cycle N..N+1.
- The datapath reflects the first step at edge N+1.
- `alt == 0` seen in cycle K:
  - the edge ending cycle K enters LANDED/CRASHED and latches `impact_velo`;
  - `step_en` = 0 from that edge on.
- `elapsed` counts RUN cycles that ended with `alt != 0`.
- `burn` follows `burn_req` / `fuel` within the same cycle; no latency.

## Structure
- Package `lander_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, LANDED, CRASHED} lander_state_t`;
  - the width parameters, `SAFE_VELO`, and the datapath reset constants 120, -50, 500.
- Sub-module `edge_detect` (rising-edge detector with reset value 1) for `start`.
- FSM, saturating time counter and burn clamp stay in `lander_controller`.

## Test plan
- Reset with `start` = 1, then hold `start` high 5 cycles -> stays IDLE, `dp_reset` = 1.
- `start` 0 -> 1 -> RUN next edge, `step_en` = 1; with `fuel` = 3, `burn_req` = 10 -> `burn` = 3; with `fuel` = 0 -> `burn` = 0.
- In RUN, drive `alt` = 0 and `velo` = -8 -> LANDED, `impact_velo` = 0xFF8, `step_en` = 0.
- Repeat with `velo` = -11 -> CRASHED.
- Repeat with `velo` = -10 -> LANDED (boundary).
- Hold RUN with `alt` = 100 for 300 cycles -> `elapsed` saturates at 255.
- Assert `reset` at `elapsed` = 17 in RUN -> IDLE next edge, `elapsed` = 0, `dp_reset` = 1.
- From CRASHED, `start` edge -> IDLE; a second edge -> RUN.

Source files
------------

// File: rtl/lander_pkg.sv
// Shared types and constants for the lunar-lander sequencer and its datapath.
// Module parameters default to the DEF_* widths below.
package lander_pkg;

  localparam int DEF_NBITS_COMB = 8;
  localparam int DEF_NBITS_BURN = 7;
  localparam int DEF_NBITS_VELO = 12;
  localparam int DEF_NBITS_ALT  = 12;
  localparam int DEF_NBITS_TIME = 8;
  localparam int DEF_SAFE_VELO  = 10;

  // Values the datapath loads while dp_reset is high.
  localparam int FUEL_INIT = 120;
  localparam int VELO_INIT = -50;
  localparam int ALT_INIT  = 500;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    LANDED  = 2'd2,
    CRASHED = 2'd3
  } lander_state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector whose history bit resets high, so a level that is
// already asserted when reset releases does not count as an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  // NOTE: sequential state is assigned with <= only, so every register
  // samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b1;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/lander_controller.sv
// Game sequencer for the lander datapath: arms a run, steps the datapath once
// per tick, clamps burn to remaining fuel and judges the touchdown.
module lander_controller
  import lander_pkg::*;
#(
  parameter int NBITS_COMB = DEF_NBITS_COMB,
  parameter int NBITS_BURN = DEF_NBITS_BURN,
  parameter int NBITS_VELO = DEF_NBITS_VELO,
  parameter int NBITS_ALT  = DEF_NBITS_ALT,
  parameter int NBITS_TIME = DEF_NBITS_TIME,
  parameter int SAFE_VELO  = DEF_SAFE_VELO
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NBITS_BURN-1:0] burn_req,
  input  logic [NBITS_COMB-1:0] fuel,
  input  logic [NBITS_VELO-1:0] velo,
  input  logic [NBITS_ALT-1:0]  alt,
  output logic                  dp_reset,
  output logic                  step_en,
  output logic [NBITS_BURN-1:0] burn,
  output logic [1:0]            state,
  output logic [NBITS_TIME-1:0] elapsed,
  output logic [NBITS_VELO-1:0] impact_velo
);

  localparam int CMP_W = (NBITS_COMB > NBITS_BURN) ? NBITS_COMB : NBITS_BURN;
  localparam logic [NBITS_TIME-1:0] TIME_MAX = '1;
  localparam logic signed [NBITS_VELO-1:0] VELO_SAFE_MIN = NBITS_VELO'(-SAFE_VELO);

  lander_state_t         state_q, state_d;
  logic [NBITS_TIME-1:0] elapsed_q, elapsed_d;
  logic [NBITS_VELO-1:0] impact_q, impact_d;

  logic             start_rise;
  logic             touchdown;
  logic             safe_landing;
  logic [CMP_W-1:0] req_ext;
  logic [CMP_W-1:0] fuel_ext;

  edge_detect u_start_edge (
    .clk    (clk_2),
    .reset  (reset),
    .sig_i  (start),
    .rise_o (start_rise)
  );

  assign touchdown    = (alt == '0);
  // Signed compare: any upward or zero velocity also counts as a landing.
  assign safe_landing = ($signed(velo) >= VELO_SAFE_MIN);
  assign req_ext      = CMP_W'(burn_req);
  assign fuel_ext     = CMP_W'(fuel);

  // State register.
  always_ff @(posedge clk_2) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; touchdown is checked before anything else in RUN and
  // start is ignored there.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_rise) state_d = RUN;
      RUN:     if (touchdown)  state_d = safe_landing ? LANDED : CRASHED;
      LANDED,
      CRASHED: if (start_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs plus the same-cycle burn clamp.
  always_comb begin
    dp_reset = 1'b0;
    step_en  = 1'b0;
    burn     = '0;
    unique case (state_q)
      IDLE: dp_reset = 1'b1;
      RUN: begin
        step_en = 1'b1;
        burn    = (req_ext <= fuel_ext) ? burn_req : NBITS_BURN'(fuel);
      end
      default: ;
    endcase
  end

  // Flight time and impact velocity; held once the run has been judged.
  always_comb begin
    elapsed_d = elapsed_q;
    impact_d  = impact_q;
    unique case (state_q)
      IDLE: begin
        elapsed_d = '0;
        impact_d  = '0;
      end
      RUN: begin
        if (touchdown) begin
          impact_d = velo;
        end else if (elapsed_q != TIME_MAX) begin
          elapsed_d = elapsed_q + NBITS_TIME'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      elapsed_q <= '0;
      impact_q  <= '0;
    end else begin
      elapsed_q <= elapsed_d;
      impact_q  <= impact_d;
    end
  end

  assign state       = state_q;
  assign elapsed     = elapsed_q;
  assign impact_velo = impact_q;

endmodule

// File: tb/tb_lander_controller.sv
// Bench for lander_controller: directed game scenarios followed by random
// switch/datapath activity, all compared against a per-tick game model.
module tb_lander_controller;

  logic        clk_2 = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  burn_req;
  logic [7:0]  fuel;
  logic [11:0] velo;
  logic [11:0] alt;
  logic        dp_reset;
  logic        step_en;
  logic [6:0]  burn;
  logic [1:0]  state;
  logic [7:0]  elapsed;
  logic [11:0] impact_velo;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model of the game, kept as plain integers.
  int m_state;    // 0 idle, 1 flying, 2 landed, 3 crashed
  int m_elapsed;
  int m_impact;   // raw 12-bit velocity pattern
  bit m_start_prev;

  lander_controller dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .start       (start),
    .burn_req    (burn_req),
    .fuel        (fuel),
    .velo        (velo),
    .alt         (alt),
    .dp_reset    (dp_reset),
    .step_en     (step_en),
    .burn        (burn),
    .state       (state),
    .elapsed     (elapsed),
    .impact_velo (impact_velo)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input int got, input int exp);
    n_vectors++;
    if (got != exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // Apply one clock tick of the game rules to the model.
  task automatic model_tick();
    bit rise;
    int v;
    if (reset) begin
      m_state = 0; m_elapsed = 0; m_impact = 0; m_start_prev = 1'b1;
      return;
    end
    rise = start && !m_start_prev;
    m_start_prev = start;
    v = int'($signed(velo));
    case (m_state)
      0: begin
        m_elapsed = 0;
        m_impact  = 0;
        if (rise) m_state = 1;
      end
      1: begin
        if (alt == 0) begin
          m_impact = int'(velo);
          m_state  = (v >= -10) ? 2 : 3;
        end else if (m_elapsed < 255) begin
          m_elapsed++;
        end
      end
      default: if (rise) m_state = 0;
    endcase
  endtask

  // Check all outputs against the model, then advance one clock.
  task automatic tick();
    int exp_burn;
    #1;
    exp_burn = 0;
    if (m_state == 1) exp_burn = (burn_req < fuel) ? int'(burn_req) : int'(fuel);
    check("state", int'(state), m_state);
    check("dp_reset", int'(dp_reset), (m_state == 0) ? 1 : 0);
    check("step_en", int'(step_en), (m_state == 1) ? 1 : 0);
    check("burn", int'(burn), exp_burn);
    check("elapsed", int'(elapsed), m_elapsed);
    check("impact_velo", int'(impact_velo), m_impact);
    @(posedge clk_2);
    model_tick();
    @(negedge clk_2);
  endtask

  task automatic start_edge();
    start = 1'b0; tick();
    start = 1'b1; tick();
  endtask

  task automatic touch_down(input int v);
    alt  = 12'd0;
    velo = 12'(v);
    tick();
    alt  = 12'd100;
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; burn_req = '0; fuel = 8'd120;
    velo = 12'(-50); alt = 12'd500;
    m_state = 0; m_elapsed = 0; m_impact = 0; m_start_prev = 1'b1;
    @(negedge clk_2);
    tick(); tick();

    // Switch already high at reset release must not arm a run.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("idle_hold_state", int'(state), 0);
    check("idle_hold_dp_reset", int'(dp_reset), 1);

    // Arm, then exercise the burn clamp.
    alt = 12'd100;
    start_edge();
    check("armed_state", int'(state), 1);
    check("armed_step_en", int'(step_en), 1);
    fuel = 8'd3; burn_req = 7'd10; #1;
    check("burn_clamped", int'(burn), 3);
    tick();
    fuel = 8'd0; #1;
    check("burn_no_fuel", int'(burn), 0);
    tick();
    fuel = 8'd80; burn_req = 7'd5;

    touch_down(-8);
    check("land_state", int'(state), 2);
    check("land_impact", int'(impact_velo), 12'hFF8);
    check("land_step_en", int'(step_en), 0);

    start_edge(); start_edge();
    touch_down(-11);
    check("crash_state", int'(state), 3);

    start_edge(); start_edge();
    touch_down(-10);
    check("boundary_state", int'(state), 2);

    // Long flight saturates the flight timer.
    start_edge(); start_edge();
    for (int i = 0; i < 300; i++) tick();
    check("elapsed_sat", int'(elapsed), 255);
    touch_down(3);
    check("upward_touch_state", int'(state), 2);

    // Reset mid-flight.
    start_edge(); start_edge();
    for (int i = 0; i < 40 && m_elapsed < 17; i++) tick();
    check("elapsed_before_reset", int'(elapsed), 17);
    reset = 1'b1; tick();
    check("reset_state", int'(state), 0);
    check("reset_elapsed", int'(elapsed), 0);
    check("reset_dp_reset", int'(dp_reset), 1);
    reset = 1'b0; start = 1'b0; tick();

    // Crashed -> idle -> run.
    start_edge();
    touch_down(-200);
    check("crash2_state", int'(state), 3);
    start_edge();
    check("ack_idle_state", int'(state), 0);
    start_edge();
    check("rerun_state", int'(state), 1);

    // Random play.
    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) start = ~start;
      burn_req = 7'($urandom);
      fuel     = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 8)) : 8'($urandom);
      velo     = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 24) - 20)
                                             : 12'($urandom);
      alt      = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
